// File: rtl/bb_sgpio_rx_pkg.sv
// Shared SGPIO receiver definitions: frame geometry, slot order, link timeout.
package bb_sgpio_rx_pkg;

  localparam int DEF_HDD_NUM        = 36;
  localparam int SGPIO_BITS_PER_DRV = 3;
  localparam int DEF_SGPIO_TIMEOUT  = 2500000;

  // Position of each per-drive bit inside its 3-bit group
  typedef enum logic [1:0] {
    SLOT_ACT  = 2'd0,
    SLOT_LOC  = 2'd1,
    SLOT_FAIL = 2'd2
  } slot_e;

  // What a given SYSCLK cycle does to the frame being assembled
  typedef enum logic [1:0] {
    FR_IDLE,
    FR_BIT,
    FR_COMMIT,
    FR_ERR
  } fr_act_e;

  // Serial slot number of a drive's ACT/LOC/FAIL bit
  function automatic int slot_idx(input int drv, input slot_e slot);
    return SGPIO_BITS_PER_DRV * drv + int'(slot);
  endfunction

endpackage

// File: rtl/bb_sgpio_sync_edge.sv
// Two-flop synchroniser plus two-deep history; edges need two matching
// samples, so a single-cycle glitch never produces a detect.
module bb_sgpio_sync_edge (
  input  logic SYSCLK,
  input  logic RESET_N,
  input  logic din,
  output logic sync_out,
  output logic rise_det,
  output logic fall_det
);

  logic       meta;
  logic [2:0] hist;  // hist[0] = c0 (newest), hist[2] = c2

  // Synchroniser and history shift
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta <= 1'b0;
      hist <= '0;
    end else begin
      meta <= din;
      hist <= {hist[1:0], meta};
    end
  end

  assign sync_out = hist[0];
  assign fall_det = (hist == 3'b100);
  assign rise_det = (hist == 3'b011);

endmodule

// File: rtl/bb_sgpio_rx.sv
// SGPIO backplane receiver: deserialises ACT/LOC/FAIL per drive, commits a
// frame when LD marks the last slot, blanks everything if CK goes quiet.
module bb_sgpio_rx
  import bb_sgpio_rx_pkg::*;
#(
  parameter int HDD_NUM     = DEF_HDD_NUM,
  parameter int TIMEOUT_CYC = DEF_SGPIO_TIMEOUT
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic               SGPIO_CK,
  input  logic               SGPIO_LD,
  input  logic               SGPIO_DATA,
  output logic [HDD_NUM-1:0] ACT_LED,
  output logic [HDD_NUM-1:0] LOC_LED,
  output logic [HDD_NUM-1:0] FAIL_LED,
  output logic               FRAME_VALID,
  output logic               FRAME_ERR,
  output logic               LINK_OK
);

  localparam int NB = SGPIO_BITS_PER_DRV * HDD_NUM;
  localparam int CW = $clog2(NB + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  // Lane 0 = CK, 1 = LD, 2 = DATA; all three see identical delay
  logic [2:0] s_out, s_rise, s_fall;

  bb_sgpio_sync_edge u_sync [2:0] (
    .SYSCLK   (SYSCLK),
    .RESET_N  (RESET_N),
    .din      ({SGPIO_DATA, SGPIO_LD, SGPIO_CK}),
    .sync_out (s_out),
    .rise_det (s_rise),
    .fall_det (s_fall)
  );

  logic ck_fall, ck_edge, ld_s, data_s;
  assign ck_fall = s_fall[0];
  assign ck_edge = s_rise[0] | s_fall[0];
  assign ld_s    = s_out[1];
  assign data_s  = s_out[2];

  // LD/DATA edges and the synced CK level are not needed
  logic unused_sync;
  assign unused_sync = ^{s_out[0], s_rise[2:1], s_fall[2:1]};

  logic [NB-1:0]      shreg, shreg_nxt;
  logic [CW-1:0]      bit_cnt;
  logic [WW-1:0]      wdog;
  logic               wd_expire;
  fr_act_e            fr_act;
  logic [HDD_NUM-1:0] act_nxt, loc_nxt, fail_nxt;

  // New bit enters at the MSB so slot 0 ends at bit 0
  assign shreg_nxt = {data_s, shreg[NB-1:1]};

  for (genvar g = 0; g < HDD_NUM; g++) begin : g_drv
    assign act_nxt[g]  = shreg_nxt[slot_idx(g, SLOT_ACT)];
    assign loc_nxt[g]  = shreg_nxt[slot_idx(g, SLOT_LOC)];
    assign fail_nxt[g] = shreg_nxt[slot_idx(g, SLOT_FAIL)];
  end

  // Classify the current cycle: plain bit, good frame end, or bad frame end
  always_comb begin
    fr_act = FR_IDLE;
    if (ck_fall) begin
      if (!ld_s)                        fr_act = FR_BIT;
      else if (bit_cnt == CW'(NB - 1))  fr_act = FR_COMMIT;
      else                              fr_act = FR_ERR;
    end
  end

  // Fires only on the cycle the watchdog would become TIMEOUT_CYC; an edge wins
  assign wd_expire = !ck_edge && (wdog == WW'(TIMEOUT_CYC - 1));

  // Watchdog: cycles since the last CK edge, saturating
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N)                    wdog <= '0;
    else if (ck_edge)                wdog <= '0;
    else if (wdog != WW'(TIMEOUT_CYC)) wdog <= wdog + 1'b1;
  end

  // Frame assembly, commit/error pulses and link-loss blanking
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      ACT_LED     <= '0;
      LOC_LED     <= '0;
      FAIL_LED    <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      LINK_OK     <= 1'b0;
    end else begin
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      if (fr_act != FR_IDLE) shreg <= shreg_nxt;
      case (fr_act)
        FR_BIT: if (bit_cnt != CW'(NB)) bit_cnt <= bit_cnt + 1'b1;
        FR_COMMIT: begin
          ACT_LED     <= act_nxt;
          LOC_LED     <= loc_nxt;
          FAIL_LED    <= fail_nxt;
          FRAME_VALID <= 1'b1;
          LINK_OK     <= 1'b1;
          bit_cnt     <= '0;
        end
        FR_ERR: begin
          FRAME_ERR <= 1'b1;
          bit_cnt   <= '0;
        end
        default: if (wd_expire) begin
          ACT_LED  <= '0;
          LOC_LED  <= '0;
          FAIL_LED <= '0;
          LINK_OK  <= 1'b0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
